param_reg_file: RTL and testbench

Parametrised architectural register file for the CPU datapath: two registered read ports, one write port, program-counter aliasing on the top address, same-cycle write-to-read bypass and a hardware clear sequencer that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write port) and replaces the fixed 16x32 register file.

---
 rtl/param_reg_file_pkg.sv | 17 +
 rtl/reg_file_clear_fsm.sv | 58 +++++
 rtl/param_reg_file.sv | 93 +++++++++
 tb/tb_param_reg_file.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared types and constants for the parametrised architectural register file.
package param_reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;

  // The top address is aliased to the PC and never stored.
  function automatic int unsigned pc_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear sequencer: sweeps zeroes through every stored entry after reset or on request,
// and gates architectural writes while the sweep runs.
module reg_file_clear_fsm
  import param_reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PC_IDX = pc_idx(ADDR_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              wr_gate_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PC_IDX - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cptr_q, cptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // A CLR request arriving mid-sweep is ignored rather than restarting it.
  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cptr_d  = '0;
        end
      end
      CLEAR: begin
        cptr_d = cptr_q + 1'b1;
        if (cptr_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cptr_q;
  assign wr_gate_o  = (state_q == IDLE) && !clr_i;

endmodule

// File: rtl/param_reg_file.sv
// Architectural register file: two registered read ports, one write port,
// PC aliasing on the top address, same-cycle write bypass and hardware clear.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned PC_IDX = pc_idx(ADDR_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] R15,
  input  logic              CLR,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem_q [PC_IDX];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_gate;
  logic              wr_acc;

  reg_file_clear_fsm #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_clr_fsm (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (CLR),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .wr_gate_o  (wr_gate)
  );

  assign wr_acc = WE3 && wr_gate && (A3 < PC_A);

  // Storage has no reset; the clear sweep defines its contents.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[A3] <= WD3;
    end
  end

  always_comb begin
    rd1_d = '0;
    if (A1 == PC_A) begin
      rd1_d = R15;
    end else if (wr_acc && (A3 == A1)) begin
      rd1_d = WD3;
    end else if (!busy && (A1 < PC_A)) begin
      rd1_d = mem_q[A1];
    end

    rd2_d = '0;
    if (A2 == PC_A) begin
      rd2_d = R15;
    end else if (wr_acc && (A3 == A2)) begin
      rd2_d = WD3;
    end else if (!busy && (A2 < PC_A)) begin
      rd2_d = mem_q[A2];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign RD1  = rd1_q;
  assign RD2  = rd2_q;
  assign BUSY = busy;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed self-checking bench for param_reg_file: default 16x32 instance and a 8x16 instance.
module tb_param_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, we3_a, clr_a, busy_a;
  logic [3:0]  a1_a, a2_a, a3_a;
  logic [31:0] wd3_a, r15_a, rd1_a, rd2_a;

  logic        rst_b, we3_b, clr_b, busy_b;
  logic [2:0]  a1_b, a2_b, a3_b;
  logic [15:0] wd3_b, r15_b, rd1_b, rd2_b;

  param_reg_file u_a (
    .CLK (clk), .RST (rst_a), .A1 (a1_a), .A2 (a2_a), .A3 (a3_a),
    .WD3 (wd3_a), .WE3 (we3_a), .R15 (r15_a), .CLR (clr_a),
    .RD1 (rd1_a), .RD2 (rd2_a), .BUSY (busy_a)
  );

  param_reg_file #(.DATA_W(16), .ADDR_W(3)) u_b (
    .CLK (clk), .RST (rst_b), .A1 (a1_b), .A2 (a2_b), .A3 (a3_b),
    .WD3 (wd3_b), .WE3 (we3_b), .R15 (r15_b), .CLR (clr_b),
    .RD1 (rd1_b), .RD2 (rd2_b), .BUSY (busy_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_a = 1'b1; we3_a = 1'b0; clr_a = 1'b0;
    a1_a = 4'd15; a2_a = 4'd0; a3_a = 4'd0; wd3_a = '0; r15_a = 32'h100;
    rst_b = 1'b1; we3_b = 1'b0; clr_b = 1'b0;
    a1_b = 3'd7; a2_b = 3'd0; a3_b = 3'd0; wd3_b = '0; r15_b = 16'hBEEF;

    // Reset state
    #3;
    check_eq("rst_rd1", rd1_a, 32'h0);
    check_eq("rst_rd2", rd2_a, 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h1);
    tick(); tick();
    check_eq("rst_hold_rd1", rd1_a, 32'h0);

    // Post-reset sweep length, PC alias while busy
    rst_a = 1'b0;
    cnt = 0;
    do begin
      tick(); cnt++;
      if (cnt == 1) begin
        check_eq("pc_alias_busy", rd1_a, 32'h100);
        check_eq("busy_first", 32'(busy_a), 32'h1);
      end
    end while (busy_a === 1'b1 && cnt < 40);
    check_eq("clr_len_reset", 32'(cnt), 32'd15);

    for (int i = 0; i < 15; i++) begin
      a1_a = 4'(i); a2_a = 4'(14 - i);
      tick();
      check_eq("zero_rd1", rd1_a, 32'h0);
      check_eq("zero_rd2", rd2_a, 32'h0);
    end
    a1_a = 4'd15;
    tick();
    check_eq("pc_alias_idle", rd1_a, 32'h100);

    // Same-cycle bypass to both ports, then array readback
    a1_a = 4'd3; a2_a = 4'd3; we3_a = 1'b1; a3_a = 4'd3; wd3_a = 32'hDEADBEEF;
    tick();
    check_eq("bypass_rd1", rd1_a, 32'hDEADBEEF);
    check_eq("bypass_rd2", rd2_a, 32'hDEADBEEF);
    we3_a = 1'b0;
    tick();
    check_eq("array_rd1", rd1_a, 32'hDEADBEEF);
    check_eq("array_rd2", rd2_a, 32'hDEADBEEF);

    // Write to PC index is dropped; PC alias wins
    a1_a = 4'd15; a2_a = 4'd3; we3_a = 1'b1; a3_a = 4'd15; wd3_a = 32'h1234; r15_a = 32'h40;
    tick();
    check_eq("pc_wr_alias", rd1_a, 32'h40);
    check_eq("pc_wr_other", rd2_a, 32'hDEADBEEF);
    we3_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      a1_a = 4'(i);
      tick();
      check_eq("pc_wr_nochg", rd1_a, (i == 3) ? 32'hDEADBEEF : 32'h0);
    end

    // Clear request with a concurrent write; writes during sweep dropped
    a3_a = 4'd7; wd3_a = 32'h55; we3_a = 1'b1; a1_a = 4'd7;
    tick();
    check_eq("r7_bypass", rd1_a, 32'h55);
    we3_a = 1'b0;
    tick();
    check_eq("r7_array", rd1_a, 32'h55);
    clr_a = 1'b1; we3_a = 1'b1; a3_a = 4'd8; wd3_a = 32'h99; a1_a = 4'd8; a2_a = 4'd7;
    tick();
    check_eq("clr_wr_drop", rd1_a, 32'h0);
    check_eq("clr_edge_rd", rd2_a, 32'h55);
    check_eq("clr_busy", 32'(busy_a), 32'h1);
    clr_a = 1'b0; a3_a = 4'd7; wd3_a = 32'hAA; a1_a = 4'd7; a2_a = 4'd15;
    cnt = 0;
    do begin
      tick(); cnt++;
      if (cnt == 1) begin
        check_eq("busy_rd_zero", rd1_a, 32'h0);
        check_eq("busy_pc_alias", rd2_a, 32'h40);
      end
      if (cnt == 5) clr_a = 1'b1;
      if (cnt == 6) clr_a = 1'b0;
    end while (busy_a === 1'b1 && cnt < 40);
    check_eq("clr_len_req", 32'(cnt), 32'd15);
    we3_a = 1'b0; a1_a = 4'd7; a2_a = 4'd8;
    tick();
    check_eq("r7_cleared", rd1_a, 32'h0);
    check_eq("r8_dropped", rd2_a, 32'h0);
    a1_a = 4'd3;
    tick();
    check_eq("r3_cleared", rd1_a, 32'h0);

    // Reset asserted mid-sweep at CPTR=6
    we3_a = 1'b1; a3_a = 4'd12; wd3_a = 32'h12;
    tick();
    we3_a = 1'b0; a1_a = 4'd15; a2_a = 4'd12;
    tick();
    check_eq("r12_pre", rd2_a, 32'h12);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("midclr_alias", rd1_a, 32'h40);
    rst_a = 1'b1;
    #1;
    check_eq("midrst_rd1", rd1_a, 32'h0);
    check_eq("midrst_rd2", rd2_a, 32'h0);
    check_eq("midrst_busy", 32'(busy_a), 32'h1);
    tick();
    rst_a = 1'b0;
    cnt = 0;
    do begin
      tick(); cnt++;
    end while (busy_a === 1'b1 && cnt < 40);
    check_eq("clr_len_rst", 32'(cnt), 32'd15);
    a1_a = 4'd12; a2_a = 4'd14;
    tick();
    check_eq("r12_swept", rd1_a, 32'h0);
    check_eq("r14_swept", rd2_a, 32'h0);

    // Narrow instance: 16-bit data, 8 addresses
    rst_b = 1'b0;
    cnt = 0;
    do begin
      tick(); cnt++;
      if (cnt == 1) check_eq("b_pc_busy", 32'(rd1_b), 32'hBEEF);
    end while (busy_b === 1'b1 && cnt < 40);
    check_eq("b_clr_len", 32'(cnt), 32'd7);
    for (int i = 0; i < 7; i++) begin
      a1_b = 3'(i);
      tick();
      check_eq("b_zero", 32'(rd1_b), 32'h0);
    end
    we3_b = 1'b1; a3_b = 3'd6; wd3_b = 16'h1234; a1_b = 3'd6; a2_b = 3'd6;
    tick();
    check_eq("b_byp_rd1", 32'(rd1_b), 32'h1234);
    check_eq("b_byp_rd2", 32'(rd2_b), 32'h1234);
    we3_b = 1'b0; a2_b = 3'd0;
    tick();
    check_eq("b_arr_r6", 32'(rd1_b), 32'h1234);
    check_eq("b_arr_r0", 32'(rd2_b), 32'h0);
    we3_b = 1'b1; a3_b = 3'd7; wd3_b = 16'h5555; a1_b = 3'd7; a2_b = 3'd6;
    tick();
    check_eq("b_pc_wr", 32'(rd1_b), 32'hBEEF);
    check_eq("b_pc_wr_r6", 32'(rd2_b), 32'h1234);
    a3_b = 3'd0; wd3_b = 16'hA5A5; a2_b = 3'd0;
    tick();
    check_eq("b_byp_r0", 32'(rd2_b), 32'hA5A5);
    we3_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a1_b = 3'(i);
      tick();
      check_eq("b_final", 32'(rd1_b), (i == 6) ? 32'h1234 : ((i == 0) ? 32'hA5A5 : 32'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
